prop_stim_sequencer: RTL and testbench

Synthesizable stimulus source for property-checking blocks that sample a check signal and a disable signal on posedge clock.
- A pattern of (check, disable) bit pairs is loaded through a valid/ready write port into an internal buffer.
- The pattern is replayed, one pair per clock, a programmable number of times.
- Sits upstream of assertion/checker modules and drives their check_sig_in/disable_sig_in directly.

---
 rtl/prop_stim_pkg.sv | 25 ++
 rtl/prop_stim_sequencer_if.sv | 25 ++
 rtl/prop_stim_buf.sv | 28 ++
 rtl/prop_stim_sequencer.sv | 155 +++++++++++++++
 tb/tb_prop_stim_sequencer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/prop_stim_pkg.sv
// Shared types and constants for the property stimulus sequencer.
// The LFSR constants are consumed only when PROP_STIM_LFSR_EN is defined.
package prop_stim_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ARMED = 2'd1,
        ST_PLAY  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic check_bit;
        logic disable_bit;
    } entry_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as a bit mask on [15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/prop_stim_sequencer_if.sv
// Pattern write port of the stimulus sequencer: valid/ready handshake
// carrying one (check, disable, last) entry per transfer.
interface prop_stim_sequencer_if;
    logic pat_valid_in;
    logic pat_ready_out;
    logic pat_check_in;
    logic pat_disable_in;
    logic pat_last_in;

    modport master (
        output pat_valid_in,
        output pat_check_in,
        output pat_disable_in,
        output pat_last_in,
        input  pat_ready_out
    );

    modport slave (
        input  pat_valid_in,
        input  pat_check_in,
        input  pat_disable_in,
        input  pat_last_in,
        output pat_ready_out
    );
endinterface

// File: rtl/prop_stim_buf.sv
// DEPTH x 2-bit pattern register file: one write port, one registered read port.
module prop_stim_buf
    import prop_stim_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_in,
    input  logic          wr_en_in,
    input  logic [AW-1:0] wr_addr_in,
    input  entry_t        wr_data_in,
    input  logic [AW-1:0] rd_addr_in,
    output entry_t        rd_data_out
);

    entry_t mem_q [DEPTH];
    entry_t rd_data_q;

    always_ff @(posedge clk_in) begin
        if (wr_en_in) begin
            mem_q[wr_addr_in] <= wr_data_in;
        end
        rd_data_q <= mem_q[rd_addr_in];
    end

    assign rd_data_out = rd_data_q;

endmodule

// File: rtl/prop_stim_sequencer.sv
// Loads a (check, disable) pattern and replays it a programmable number of times.
// Optional PROP_STIM_LFSR_EN adds pseudo-random disable injection during playback.
module prop_stim_sequencer
    import prop_stim_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int REP_W = 8
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    prop_stim_sequencer_if.slave   pat,
    input  logic                   start_in,
    input  logic [REP_W-1:0]       repeat_in,
    output logic                   check_sig_out,
    output logic                   disable_sig_out,
    output logic                   busy_out,
    output logic                   done_out,
    output logic                   ovf_out
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW:0]     LAST_IDX = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]     ONE_W    = (AW+1)'(1);
    localparam logic [AW-1:0]   ONE_A    = AW'(1);
    localparam logic [REP_W-1:0] ONE_R   = REP_W'(1);

    state_t           state_q, state_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      len_q, len_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [REP_W-1:0] pass_q, pass_d;
    logic             ovf_q, ovf_d;

    logic             pat_ready;
    logic             wr_en;
    entry_t           wr_data;
    entry_t           rd_data;
    logic [AW:0]      len_m1;
    logic             play;
    logic             inject;

    prop_stim_buf #(.DEPTH(DEPTH)) u_buf (
        .clk_in      (clk_in),
        .wr_en_in    (wr_en),
        .wr_addr_in  (wr_ptr_q[AW-1:0]),
        .wr_data_in  (wr_data),
        .rd_addr_in  (rd_ptr_d),
        .rd_data_out (rd_data)
    );

    // rd_ptr_q is the entry currently on the outputs; rd_ptr_d is fetched for the next cycle
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        len_d     = len_q;
        rd_ptr_d  = rd_ptr_q;
        rep_d     = rep_q;
        pass_d    = pass_q;
        wr_en     = 1'b0;
        wr_data   = '{check_bit: pat.pat_check_in, disable_bit: pat.pat_disable_in};
        pat_ready = (state_q == ST_LOAD) && (wr_ptr_q < DEPTH_W);
        len_m1    = len_q - ONE_W;
        ovf_d     = ovf_q | (pat.pat_valid_in & ~pat_ready);

        case (state_q)
            ST_LOAD: begin
                if (pat.pat_valid_in && pat_ready) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + ONE_W;
                    if (pat.pat_last_in || (wr_ptr_q == LAST_IDX)) begin
                        len_d   = wr_ptr_q + ONE_W;
                        state_d = ST_ARMED;
                    end
                end
            end
            ST_ARMED: begin
                if (start_in) begin
                    rep_d    = (repeat_in == '0) ? ONE_R : repeat_in;
                    rd_ptr_d = '0;
                    pass_d   = '0;
                    state_d  = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if ({1'b0, rd_ptr_q} == len_m1) begin
                    if (pass_q == rep_q - ONE_R) begin
                        state_d = ST_DONE;
                    end else begin
                        pass_d   = pass_q + ONE_R;
                        rd_ptr_d = '0;
                    end
                end else begin
                    rd_ptr_d = rd_ptr_q + ONE_A;
                end
            end
            ST_DONE: begin
                state_d = ST_ARMED;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= ST_LOAD;
            wr_ptr_q <= '0;
            len_q    <= '0;
            rd_ptr_q <= '0;
            rep_q    <= '0;
            pass_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            len_q    <= len_d;
            rd_ptr_q <= rd_ptr_d;
            rep_q    <= rep_d;
            pass_q   <= pass_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef PROP_STIM_LFSR_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = (state_q == ST_PLAY) ? lfsr_step(lfsr_q) : lfsr_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign inject = (lfsr_q[3:0] == 4'hF);
`else
    assign inject = 1'b0;
`endif

    assign play              = (state_q == ST_PLAY);
    assign pat.pat_ready_out = pat_ready;
    assign check_sig_out     = play & rd_data.check_bit;
    assign disable_sig_out   = play & (rd_data.disable_bit | inject);
    assign busy_out          = play;
    assign done_out          = (state_q == ST_DONE);
    assign ovf_out           = ovf_q;

endmodule

// File: tb/tb_prop_stim_sequencer.sv
// Scoreboard bench for prop_stim_sequencer; models LFSR injection when
// PROP_STIM_LFSR_EN is defined.
module tb_prop_stim_sequencer;

    logic       clk = 1'b0;
    logic       rst_in;
    logic       start_in;
    logic [7:0] repeat_in;
    logic       check_sig_out, disable_sig_out, busy_out, done_out, ovf_out;

    int tests_run = 0;
    int tests_failed = 0;

    logic       pat_c [16];
    logic       pat_d [16];
    logic [3:0] exp_q [$];

`ifdef PROP_STIM_LFSR_EN
    logic [15:0] lfsr_m;
`endif

    prop_stim_sequencer_if pif ();

    prop_stim_sequencer #(.DEPTH(16), .REP_W(8)) dut (
        .clk_in          (clk),
        .rst_in          (rst_in),
        .pat             (pif.slave),
        .start_in        (start_in),
        .repeat_in       (repeat_in),
        .check_sig_out   (check_sig_out),
        .disable_sig_out (disable_sig_out),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .ovf_out         (ovf_out)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
`ifdef PROP_STIM_LFSR_EN
        lfsr_m = 16'hACE1;
`endif
        exp_q.delete();
    endtask

    task automatic write_entry(input logic c, input logic d, input logic last);
        pif.pat_valid_in   = 1'b1;
        pif.pat_check_in   = c;
        pif.pat_disable_in = d;
        pif.pat_last_in    = last;
        step();
        pif.pat_valid_in   = 1'b0;
        pif.pat_last_in    = 1'b0;
        $display("[TB] write c=%0d d=%0d last=%0d", c, d, last);
    endtask

    task automatic load_basic;
        pat_c[0] = 1'b1; pat_d[0] = 1'b0;
        pat_c[1] = 1'b0; pat_d[1] = 1'b0;
        pat_c[2] = 1'b1; pat_d[2] = 1'b1;
        pat_c[3] = 1'b0; pat_d[3] = 1'b1;
        for (int i = 0; i < 4; i++) write_entry(pat_c[i], pat_d[i], i == 3);
    endtask

    // Expected output word {check, disable, busy, done} for one playback cycle
    task automatic push_entry(input logic c, input logic d);
        logic inj;
        inj = 1'b0;
`ifdef PROP_STIM_LFSR_EN
        inj = (lfsr_m[3:0] == 4'hF);
        lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
`endif
        exp_q.push_back({c, d | inj, 1'b1, 1'b0});
    endtask

    task automatic start_play(input logic [7:0] rep, input int len, input int pulse_at,
                              input string name);
        int eff;
        int k;
        logic [3:0] exp, obs;
        eff = (rep == 8'd0) ? 1 : int'(rep);
        for (int r = 0; r < eff; r++)
            for (int i = 0; i < len; i++) push_entry(pat_c[i], pat_d[i]);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0000);
        repeat_in = rep;
        start_in  = 1'b1;
        k = 0;
        while (exp_q.size() > 0) begin
            if (k > 0) start_in = (k == pulse_at);
            step();
            start_in = 1'b0;
            exp = exp_q.pop_front();
            obs = {check_sig_out, disable_sig_out, busy_out, done_out};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL %s cycle %0d: got {chk,dis,busy,done}=%b expected %b", name, k, obs, exp);
            end
            k++;
        end
        $display("[TB] playback %s rep=%0d len=%0d cycles=%0d", name, rep, len, k);
    endtask

    task automatic test_reset;
        do_reset();
        tests_run++;
        if ({check_sig_out, disable_sig_out, busy_out, done_out} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected 0000",
                     {check_sig_out, disable_sig_out, busy_out, done_out});
        end
        tests_run++;
        if (pif.pat_ready_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b expected 1", pif.pat_ready_out);
        end
        tests_run++;
        if (ovf_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ovf: got %b expected 0", ovf_out);
        end
    endtask

    task automatic test_basic;
        do_reset();
        load_basic();
        tests_run++;
        if (pif.pat_ready_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_armed_ready: got %b expected 0", pif.pat_ready_out);
        end
        start_play(8'd2, 4, -1, "basic");
        tests_run++;
        if (ovf_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_ovf: got %b expected 0", ovf_out);
        end
    endtask

    task automatic test_overflow;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            pat_c[i] = 1'($urandom_range(1));
            pat_d[i] = 1'($urandom_range(1));
            write_entry(pat_c[i], pat_d[i], 1'b0);
        end
        tests_run++;
        if (pif.pat_ready_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_ready: got %b expected 0", pif.pat_ready_out);
        end
        tests_run++;
        if (ovf_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_ovf_early: got %b expected 0", ovf_out);
        end
        write_entry(1'b1, 1'b1, 1'b0);
        tests_run++;
        if (ovf_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_set: got %b expected 1", ovf_out);
        end
        step();
        tests_run++;
        if (ovf_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_sticky: got %b expected 1", ovf_out);
        end
        start_play(8'd1, 16, -1, "full16");
        tests_run++;
        if (ovf_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_after_play: got %b expected 1", ovf_out);
        end
    endtask

    task automatic test_single_entry;
        do_reset();
        pat_c[0] = 1'b1;
        pat_d[0] = 1'b1;
        write_entry(1'b1, 1'b1, 1'b1);
        start_play(8'd0, 1, -1, "rep_zero");
        start_play(8'd3, 1, -1, "len1_rep3");
    endtask

    task automatic test_reset_mid;
        logic [3:0] exp, obs;
        do_reset();
        load_basic();
        for (int i = 0; i < 3; i++) push_entry(pat_c[i], pat_d[i]);
        repeat_in = 8'd2;
        start_in  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            start_in = 1'b0;
            exp = exp_q.pop_front();
            obs = {check_sig_out, disable_sig_out, busy_out, done_out};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL mid_play cycle %0d: got %b expected %b", k, obs, exp);
            end
        end
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        for (int k = 0; k < 2; k++) begin
            obs = {check_sig_out, disable_sig_out, busy_out, done_out};
            tests_run++;
            if (obs !== 4'b0000) begin
                tests_failed++;
                $display("FAIL mid_reset_outputs cycle %0d: got %b expected 0000", k, obs);
            end
            tests_run++;
            if (pif.pat_ready_out !== 1'b1) begin
                tests_failed++;
                $display("FAIL mid_reset_ready cycle %0d: got %b expected 1", k, pif.pat_ready_out);
            end
            step();
        end
        $display("[TB] reset during playback");
    endtask

    task automatic test_replay;
        do_reset();
        load_basic();
        start_play(8'd1, 4, -1, "replay_first");
        start_play(8'd1, 4, 2, "replay_again");
    endtask

    task automatic test_long_run;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            pat_c[i] = 1'($urandom_range(1));
            pat_d[i] = 1'b0;
            write_entry(pat_c[i], pat_d[i], i == 15);
        end
        start_play(8'd16, 16, -1, "long256");
    endtask

    initial begin
        rst_in             = 1'b0;
        start_in           = 1'b0;
        repeat_in          = 8'd0;
        pif.pat_valid_in   = 1'b0;
        pif.pat_check_in   = 1'b0;
        pif.pat_disable_in = 1'b0;
        pif.pat_last_in    = 1'b0;

        test_reset();
        test_basic();
        test_overflow();
        test_single_entry();
        test_reset_mid();
        test_replay();
        test_long_run();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
